// File: rtl/fifo_word_serializer.sv
// rtl/fifo_word_serializer.sv - drains a word FIFO and emits each word as narrow valid/ready beats
module fifo_word_serializer #(
  parameter int word_width = 32,
  parameter int beat_width = 8,
  parameter bit msb_first  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [word_width-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [beat_width-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [15:0]           word_count
);

  localparam int beats = word_width / beat_width;
  localparam int idx_w = (beats > 1) ? $clog2(beats) : 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [word_width-1:0] shift_q, shift_d;
  logic [idx_w-1:0]      idx_q, idx_d;
  logic                  last_q, last_d;
  logic [15:0]           count_q, count_d;
  logic                  accept;

  // Beat handshake and pop decision; the pop on the last beat gives zero-bubble word chaining
  always_comb begin
    accept   = (state_q == ST_SEND) && out_ready;
    fifo_pop = !reset && !fifo_empty && ((state_q == ST_EMPTY) || (accept && last_q));
  end

  // Next-state: load on pop, shift the outgoing beat away on each accepted non-last beat
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    last_d  = last_q;
    count_d = count_q;
    if (accept && last_q) begin
      count_d = count_q + 16'd1;
    end
    if (fifo_pop) begin
      state_d = ST_SEND;
      shift_d = fifo_data;
      idx_d   = '0;
      last_d  = (beats == 1);
    end else if (accept) begin
      if (last_q) begin
        state_d = ST_EMPTY;
        last_d  = 1'b0;
      end else begin
        shift_d = msb_first ? (shift_q << beat_width) : (shift_q >> beat_width);
        idx_d   = idx_q + idx_w'(1);
        last_d  = (idx_q == idx_w'(beats - 2));
      end
    end
  end

  // State register with asynchronous clear of the held word and the word counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      shift_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  // Outputs come straight from flops; the current beat always sits at the shifting end
  always_comb begin
    out_valid  = (state_q == ST_SEND);
    busy       = (state_q == ST_SEND);
    out_last   = last_q;
    out_data   = msb_first ? shift_q[word_width-1 -: beat_width] : shift_q[beat_width-1:0];
    word_count = count_q;
  end

endmodule
